// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the D/E, E/M and M/W boundaries: payload, PC, valid and Tnew
// with stall/flush control, plus saturating stall and bubble event counters for hazard debug.
module pipe_stage_reg #(
    parameter int DATA_W   = 128,
    parameter int PC_W     = 32,
    parameter int TNEW_W   = 2,
    parameter int TNEW_DEC = 1,
    parameter int CNT_W    = 16,
    parameter int NEG_EDGE = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Cnt_Clr,
    input  logic              Valid_In,
    input  logic [DATA_W-1:0] Data_In,
    input  logic [PC_W-1:0]   Pc_In,
    input  logic [TNEW_W-1:0] Tnew_In,
    output logic              Valid_Out,
    output logic [DATA_W-1:0] Data_Out,
    output logic [PC_W-1:0]   Pc_Out,
    output logic [TNEW_W-1:0] Tnew_Out,
    output logic [CNT_W-1:0]  Stall_Cnt,
    output logic [CNT_W-1:0]  Bubble_Cnt
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
        logic [TNEW_W-1:0] tnew;
    } slot_t;

    slot_t             slot_q, slot_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [TNEW_W-1:0] tnew_next;
    logic              stall_ev;
    logic              bubble_ev;

    // Tnew counts down one stage per advance and never wraps below zero.
    generate
        if (TNEW_DEC != 0) begin : g_tnew_dec
            assign tnew_next = (Tnew_In != '0) ? (Tnew_In - TNEW_W'(1)) : '0;
        end else begin : g_tnew_pass
            assign tnew_next = Tnew_In;
        end
    endgenerate

    always_comb begin
        slot_d    = slot_q;
        stall_ev  = 1'b0;
        bubble_ev = 1'b0;
        if (Flush) begin
            slot_d    = '0;
            slot_d.pc = Pc_In;
            bubble_ev = 1'b1;
        end else if (Stall) begin
            stall_ev = 1'b1;
        end else if (Valid_In) begin
            slot_d.valid = 1'b1;
            slot_d.data  = Data_In;
            slot_d.pc    = Pc_In;
            slot_d.tnew  = tnew_next;
        end else begin
            // An empty upstream slot advances as a bubble but keeps its PC.
            slot_d    = '0;
            slot_d.pc = Pc_In;
            bubble_ev = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (Cnt_Clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (stall_ev && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (bubble_ev && (bubble_cnt_q != '1)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    generate
        if (NEG_EDGE != 0) begin : g_negedge
            always_ff @(negedge Clk or posedge Reset) begin
                if (Reset) begin
                    slot_q       <= '0;
                    stall_cnt_q  <= '0;
                    bubble_cnt_q <= '0;
                end else begin
                    slot_q       <= slot_d;
                    stall_cnt_q  <= stall_cnt_d;
                    bubble_cnt_q <= bubble_cnt_d;
                end
            end
        end else begin : g_posedge
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    slot_q       <= '0;
                    stall_cnt_q  <= '0;
                    bubble_cnt_q <= '0;
                end else begin
                    slot_q       <= slot_d;
                    stall_cnt_q  <= stall_cnt_d;
                    bubble_cnt_q <= bubble_cnt_d;
                end
            end
        end
    endgenerate

    assign Valid_Out  = slot_q.valid;
    assign Data_Out   = slot_q.data;
    assign Pc_Out     = slot_q.pc;
    assign Tnew_Out   = slot_q.tnew;
    assign Stall_Cnt  = stall_cnt_q;
    assign Bubble_Cnt = bubble_cnt_q;

endmodule
